// File: rtl/countdown_pkg.sv
// -----------------------------------------------------------------------------
// countdown_pkg
// Shared definitions for the MM:SS countdown timer and the up-count time
// tracker: the timer state encoding, BCD digit limits, the default power-up
// time, the digit field positions inside a packed 16-bit MM:SS word, and two
// helpers (BCD time validation and a single-second BCD decrement).
//
// Packed time layout: [15:12] min tens, [11:8] min units,
//                     [7:4]   sec tens, [3:0]  sec units.
// -----------------------------------------------------------------------------
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0]  DIGIT_MAX          = 4'd9;
    localparam logic [3:0]  SEC_TENS_MAX       = 4'd5;
    localparam logic [15:0] DEFAULT_RESET_TIME = 16'h0500;

    localparam int DIGIT_W       = 4;
    localparam int SEC_UNITS_LSB = 0;
    localparam int SEC_TENS_LSB  = 4;
    localparam int MIN_UNITS_LSB = 8;
    localparam int MIN_TENS_LSB  = 12;

    // True when every digit is decimal and the seconds field is below 60.
    function automatic logic bcd_time_valid(input logic [15:0] t);
        return (t[MIN_TENS_LSB  +: DIGIT_W] <= DIGIT_MAX)    &&
               (t[MIN_UNITS_LSB +: DIGIT_W] <= DIGIT_MAX)    &&
               (t[SEC_TENS_LSB  +: DIGIT_W] <= SEC_TENS_MAX) &&
               (t[SEC_UNITS_LSB +: DIGIT_W] <= DIGIT_MAX);
    endfunction

    // One-second decrement with a ripple borrow from sec units up to min
    // tens. Callers must never pass 00:00; the min tens digit would wrap.
    function automatic logic [15:0] bcd_time_dec(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[SEC_UNITS_LSB +: DIGIT_W] != 4'd0) begin
            r[SEC_UNITS_LSB +: DIGIT_W] = t[SEC_UNITS_LSB +: DIGIT_W] - 4'd1;
        end else begin
            r[SEC_UNITS_LSB +: DIGIT_W] = DIGIT_MAX;
            if (t[SEC_TENS_LSB +: DIGIT_W] != 4'd0) begin
                r[SEC_TENS_LSB +: DIGIT_W] = t[SEC_TENS_LSB +: DIGIT_W] - 4'd1;
            end else begin
                r[SEC_TENS_LSB +: DIGIT_W] = SEC_TENS_MAX;
                if (t[MIN_UNITS_LSB +: DIGIT_W] != 4'd0) begin
                    r[MIN_UNITS_LSB +: DIGIT_W] = t[MIN_UNITS_LSB +: DIGIT_W] - 4'd1;
                end else begin
                    r[MIN_UNITS_LSB +: DIGIT_W] = DIGIT_MAX;
                    r[MIN_TENS_LSB  +: DIGIT_W] = t[MIN_TENS_LSB +: DIGIT_W] - 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides clk down to a one-cycle strobe every TICK_DIV enabled cycles.
// The counter advances only while en is high and holds its value otherwise,
// so a paused user of the strobe resumes mid-period. clear forces the count
// back to zero and wins over en.
//
// Parameters: TICK_DIV - enabled clk cycles per tick (>= 2)
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset (count -> 0)
//   en    in  advance the count this cycle
//   clear in  restart the period from zero
//   tick  out high in the enabled cycle where the count wraps
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int                CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // The tick is combinational so the consumer acts in the same cycle the
    // count wraps.
    always_comb begin
        tick    = en && (count_q == CNT_MAX);
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            if (tick) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// -----------------------------------------------------------------------------
// bcd_countdown_timer
// Counts a packed BCD MM:SS value down to 00:00 at one step per second.
// A valid load parks the timer in IDLE with the new value; start runs it,
// pause holds it, and reaching 00:00 latches EXPIRED until the next load.
//
// Optional feature macro: LAST_MINUTE_WARN_EN (warn output under one minute
// remaining while RUN/PAUSED; tied low when the macro is undefined).
//
// Parameters:
//   TICK_DIV   - clk cycles per one-second decrement (>= 2)
//   RESET_TIME - BCD time shown after reset
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   load       in   strobe: capture load_value
//   load_value in   BCD MM:SS to load
//   start      in   strobe: begin or resume counting
//   pause      in   strobe: suspend counting
//   time_bcd   out  remaining time, BCD MM:SS
//   running    out  high while counting
//   expired    out  one-cycle pulse when 00:00 is first shown
//   done       out  high while holding at 00:00 after expiry
//   load_err   out  one-cycle pulse after a rejected load
//   warn       out  last-minute warning
// -----------------------------------------------------------------------------
module bcd_countdown_timer
    import countdown_pkg::*;
#(
    parameter int          TICK_DIV   = 100000000,
    parameter logic [15:0] RESET_TIME = DEFAULT_RESET_TIME
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        start,
    input  logic        pause,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        expired,
    output logic        done,
    output logic        load_err,
    output logic        warn
);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] time_q;
    logic [15:0] time_d;
    logic        expired_q;
    logic        expired_d;
    logic        load_err_q;
    logic        load_err_d;

    logic        load_ok;
    logic        presc_en;
    logic        presc_clear;
    logic        tick;
    logic [15:0] time_dec;

    assign load_ok  = bcd_time_valid(load_value);
    assign time_dec = bcd_time_dec(time_q);

    // Any load strobe owns the cycle: the prescaler does not advance, so a
    // tick landing on a load (valid or rejected) is dropped rather than
    // deferred. A valid load also restarts the one-second period.
    assign presc_en    = (state_q == RUN) && !load;
    assign presc_clear = load && load_ok;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (presc_en),
        .clear (presc_clear),
        .tick  (tick)
    );

    // Next-state logic. Ticks only occur in RUN, and RUN is never entered
    // with 00:00, so the decrement never underflows. When the decrement
    // lands on 00:00 expiry takes precedence over a simultaneous pause.
    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        expired_d  = 1'b0;
        load_err_d = 1'b0;

        if (load) begin
            if (load_ok) begin
                time_d  = load_value;
                state_d = IDLE;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (tick) begin
            time_d = time_dec;
            if (time_dec == 16'h0000) begin
                state_d   = EXPIRED;
                expired_d = 1'b1;
            end else if (pause) begin
                state_d = PAUSED;
            end
        end else if (pause && (state_q == RUN)) begin
            state_d = PAUSED;
        end else if (start) begin
            if ((state_q == IDLE) && (time_q != 16'h0000)) begin
                state_d = RUN;
            end else if (state_q == PAUSED) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            time_q     <= RESET_TIME;
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            expired_q  <= expired_d;
            load_err_q <= load_err_d;
        end
    end

    assign time_bcd = time_q;
    assign running  = (state_q == RUN);
    assign done     = (state_q == EXPIRED);
    assign expired  = expired_q;
    assign load_err = load_err_q;

`ifdef LAST_MINUTE_WARN_EN
    logic warn_q;
    logic warn_d;

    // Computed from the next state and time so the flag lines up with the
    // time_bcd value it describes.
    always_comb begin
        warn_d = ((state_d == RUN) || (state_d == PAUSED)) &&
                 (time_d[MIN_TENS_LSB +: 2*DIGIT_W] == 8'h00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= warn_d;
        end
    end

    assign warn = warn_q;
`else
    assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_bcd_countdown_timer
// Self-checking bench for bcd_countdown_timer with TICK_DIV=4. A reference
// model tracks the remaining time as a plain count of seconds and converts
// it to BCD for comparison; a compare process checks every output against
// it on each falling edge. Directed scenarios add literal expectations,
// followed by a randomized stimulus phase.
// -----------------------------------------------------------------------------
module tb_bcd_countdown_timer;

    localparam int          TICK_DIV   = 4;
    localparam logic [15:0] RESET_TIME = 16'h0500;

    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_PAUSED  = 2;
    localparam int M_EXPIRED = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_value = 16'h0000;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [15:0] time_bcd;
    logic        running;
    logic        expired;
    logic        done;
    logic        load_err;
    logic        warn;

    int n_compared   = 0;
    int n_mismatched = 0;

    int m_secs  = 0;
    int m_phase = 0;
    int m_mode  = M_IDLE;
    bit m_expired  = 1'b0;
    bit m_load_err = 1'b0;
    bit m_warn     = 1'b0;
    bit check_en   = 1'b0;

    always #5 clk = ~clk;

    bcd_countdown_timer #(
        .TICK_DIV   (TICK_DIV),
        .RESET_TIME (RESET_TIME)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .time_bcd   (time_bcd),
        .running    (running),
        .expired    (expired),
        .done       (done),
        .load_err   (load_err),
        .warn       (warn)
    );

    function automatic logic [15:0] secs_to_bcd(input int s);
        int m;
        int ss;
        m  = s / 60;
        ss = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic bit bcd_ok(input logic [15:0] v);
        int x;
        x = int'(v);
        return ((x % 16) <= 9) && (((x / 16) % 16) <= 5) &&
               (((x / 256) % 16) <= 9) && ((x / 4096) <= 9);
    endfunction

    function automatic int bcd_to_secs(input logic [15:0] v);
        int x;
        x = int'(v);
        return ((x / 4096) * 10 + (x / 256) % 16) * 60 +
               ((x / 16) % 16) * 10 + (x % 16);
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    // Drive one cycle of strobes starting at a falling edge; returns at the
    // next falling edge with the strobes cleared.
    task automatic applyStimulus(input bit ld, input logic [15:0] lv,
                                 input bit st, input bit ps);
        load       = ld;
        load_value = lv;
        start      = st;
        pause      = ps;
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
    endtask

    // Reference model: seconds remaining, mode, and the position within the
    // current second, updated from the inputs seen at each rising edge.
    always @(posedge clk) begin : ref_model
        bit tick_now;
        if (rst) begin
            m_secs     = bcd_to_secs(RESET_TIME);
            m_phase    = 0;
            m_mode     = M_IDLE;
            m_expired  = 1'b0;
            m_load_err = 1'b0;
            check_en   = 1'b1;
        end else begin
            m_expired  = 1'b0;
            m_load_err = 1'b0;
            if (load) begin
                if (bcd_ok(load_value)) begin
                    m_secs  = bcd_to_secs(load_value);
                    m_mode  = M_IDLE;
                    m_phase = 0;
                end else begin
                    m_load_err = 1'b1;
                end
            end else begin
                tick_now = 1'b0;
                if (m_mode == M_RUN) begin
                    if (m_phase == TICK_DIV - 1) begin
                        m_phase  = 0;
                        tick_now = 1'b1;
                    end else begin
                        m_phase = m_phase + 1;
                    end
                end
                if (tick_now) begin
                    m_secs = m_secs - 1;
                    if (m_secs == 0) begin
                        m_mode    = M_EXPIRED;
                        m_expired = 1'b1;
                    end else if (pause) begin
                        m_mode = M_PAUSED;
                    end
                end else if (pause && m_mode == M_RUN) begin
                    m_mode = M_PAUSED;
                end else if (start) begin
                    if (m_mode == M_IDLE && m_secs != 0) begin
                        m_mode = M_RUN;
                    end else if (m_mode == M_PAUSED) begin
                        m_mode = M_RUN;
                    end
                end
            end
        end
`ifdef LAST_MINUTE_WARN_EN
        m_warn = (m_mode == M_RUN || m_mode == M_PAUSED) && (m_secs < 60);
`else
        m_warn = 1'b0;
`endif
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("time_bcd", time_bcd, secs_to_bcd(m_secs));
            checkOutput("running",  16'(running),  16'(m_mode == M_RUN));
            checkOutput("done",     16'(done),     16'(m_mode == M_EXPIRED));
            checkOutput("expired",  16'(expired),  16'(m_expired));
            checkOutput("load_err", 16'(load_err), 16'(m_load_err));
            checkOutput("warn",     16'(warn),     16'(m_warn));
        end
    end

    initial begin
        int r;
        int sel;
        logic [15:0] v;

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset then idle: no ticks without start.
        repeat (10) @(negedge clk);
        checkOutput("idle_time", time_bcd, 16'h0500);
        checkOutput("idle_running", 16'(running), 16'h0000);
        checkOutput("idle_done", 16'(done), 16'h0000);

        // Short countdown to expiry.
        applyStimulus(1'b1, 16'h0002, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("cd_first_dec", time_bcd, 16'h0001);
        repeat (4) @(negedge clk);
        checkOutput("cd_zero", time_bcd, 16'h0000);
        checkOutput("cd_expired_pulse", 16'(expired), 16'h0001);
        checkOutput("cd_done", 16'(done), 16'h0001);
        @(negedge clk);
        checkOutput("cd_expired_one_cycle", 16'(expired), 16'h0000);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("cd_start_ignored", 16'(running), 16'h0000);
        checkOutput("cd_done_held", 16'(done), 16'h0001);

        // Full borrow chain.
        applyStimulus(1'b1, 16'h1000, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("borrow_chain", time_bcd, 16'h0959);
        repeat (4) @(negedge clk);
        checkOutput("borrow_next", time_bcd, 16'h0958);

        // Pause keeps the prescaler position.
        applyStimulus(1'b1, 16'h0030, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("pause_running", 16'(running), 16'h0000);
        repeat (20) @(negedge clk);
        checkOutput("pause_frozen", time_bcd, 16'h0030);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("resume_hold", time_bcd, 16'h0030);
        @(negedge clk);
        checkOutput("resume_dec", time_bcd, 16'h0029);

        // Rejected loads and a zero load.
        applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0570, 1'b0, 1'b0);
        checkOutput("bad_sec_tens_err", 16'(load_err), 16'h0001);
        checkOutput("bad_sec_tens_time", time_bcd, 16'h0100);
        applyStimulus(1'b1, 16'h0A00, 1'b0, 1'b0);
        checkOutput("bad_min_units_err", 16'(load_err), 16'h0001);
        checkOutput("bad_min_units_time", time_bcd, 16'h0100);
        @(negedge clk);
        checkOutput("load_err_one_cycle", 16'(load_err), 16'h0000);
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("zero_start_running", 16'(running), 16'h0000);
        checkOutput("zero_start_done", 16'(done), 16'h0000);

        // Load colliding with a tick.
        applyStimulus(1'b1, 16'h0200, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 16'h0130, 1'b0, 1'b0);
        checkOutput("collide_time", time_bcd, 16'h0130);
        checkOutput("collide_running", 16'(running), 16'h0000);
        repeat (8) @(negedge clk);
        checkOutput("collide_no_dec", time_bcd, 16'h0130);

`ifdef LAST_MINUTE_WARN_EN
        applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("warn_before", 16'(warn), 16'h0000);
        @(negedge clk);
        checkOutput("warn_time", time_bcd, 16'h0059);
        checkOutput("warn_rise", 16'(warn), 16'h0001);
        repeat (59 * 4) @(negedge clk);
        checkOutput("warn_expiry_done", 16'(done), 16'h0001);
        checkOutput("warn_fall", 16'(warn), 16'h0000);
`endif

        // Mid-count reset.
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_mid_time", time_bcd, 16'h0500);
        checkOutput("rst_mid_running", 16'(running), 16'h0000);

        // Randomized phase.
        for (int i = 0; i < 4000; i++) begin
            r   = $urandom_range(0, 999);
            sel = $urandom_range(0, 9);
            if (sel < 5) begin
                v = secs_to_bcd($urandom_range(0, 25));
            end else if (sel < 7) begin
                v = secs_to_bcd($urandom_range(0, 5999));
            end else begin
                v = 16'($urandom);
            end
            if (r < 3) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else if (r < 40) begin
                applyStimulus(1'b1, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else if (r < 100) begin
                applyStimulus(1'b0, v, 1'b1, 1'b0);
            end else if (r < 130) begin
                applyStimulus(1'b0, v, 1'b0, 1'b1);
            end else if (r < 140) begin
                applyStimulus(1'b0, v, 1'b1, 1'b1);
            end else begin
                @(negedge clk);
            end
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
